// File: rtl/mult_accum_pkg.sv
// Shared types and widths for the multiply-accumulate slice.
package mult_accum_pkg;

  // Operand and product widths of the array multiplier.
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Counters must represent N_TERMS itself (up to 255) without wrapping.
  localparam int CNT_W  = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  // ACCUM: collecting terms; HOLD: presenting a finished sum.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Converts a term count into the counter type.
  function automatic cnt_t to_cnt(input int n);
    return cnt_t'(n);
  endfunction

endpackage

// File: rtl/mult_accum_4bit_arrmult.sv
// ArrMult_4bit: combinational 4x4 unsigned array multiplier.
// Each row adds one shifted partial product into the running sum.
module ArrMult_4bit
  import mult_accum_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] row [OP_W+1];

  assign row[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_row
      logic [PROD_W-1:0] pp;
      // Partial product a & b[gi], aligned to bit gi.
      assign pp         = PROD_W'({OP_W{b[gi]}} & a) << gi;
      assign row[gi+1]  = row[gi] + pp;
    end
  endgenerate

  assign prod = row[OP_W];

endmodule

// File: rtl/mult_accum_4bit.sv
// mult_accum_4bit: multiply-accumulate wrapper around ArrMult_4bit.
// Accepts operand pairs over valid/ready, sums N_TERMS products and
// presents the sum on a valid/ready result port.
// Build option: MULT_ACCUM_SAT_EN selects saturating accumulation
// (clamp to all-ones) instead of modulo wrap.
module mult_accum_4bit
  import mult_accum_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam cnt_t N_CNT    = to_cnt(N_TERMS);
  localparam cnt_t LAST_CNT = to_cnt(N_TERMS - 1);

  state_t            state_reg, state_next;
  logic [OP_W-1:0]   op_a_reg, op_a_next;
  logic [OP_W-1:0]   op_b_reg, op_b_next;
  logic              pipe_valid_reg, pipe_valid_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic              sticky_reg, sticky_next;
  cnt_t              acc_cnt_reg, acc_cnt_next;
  cnt_t              add_cnt_reg, add_cnt_next;
  logic              out_valid_reg, out_valid_next;
  logic [ACC_W-1:0]  acc_out_reg, acc_out_next;
  logic              overflow_reg, overflow_next;
  logic              in_ready_reg, in_ready_next;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_full;
  logic [ACC_W-1:0]  add_acc;
  logic              add_sticky;
  logic              take;

  ArrMult_4bit u_mult (
    .a    (op_a_reg),
    .b    (op_b_reg),
    .prod (prod)
  );

  // One extra bit catches the carry out of the accumulator.
  assign sum_full   = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign add_sticky = sticky_reg | sum_full[ACC_W];

`ifdef MULT_ACCUM_SAT_EN
  // Once any addition has overflowed, the sum stays pinned at all-ones.
  assign add_acc = (sum_full[ACC_W] || sticky_reg) ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign add_acc = sum_full[ACC_W-1:0];
`endif

  assign take = in_valid & in_ready_reg;

  // Next-state and datapath update: capture, accumulate, publish, flush.
  always_comb begin
    state_next      = state_reg;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    pipe_valid_next = 1'b0;
    acc_next        = acc_reg;
    sticky_next     = sticky_reg;
    acc_cnt_next    = acc_cnt_reg;
    add_cnt_next    = add_cnt_reg;
    out_valid_next  = out_valid_reg;
    acc_out_next    = acc_out_reg;
    overflow_next   = overflow_reg;

    if (take) begin
      op_a_next       = a;
      op_b_next       = b;
      pipe_valid_next = 1'b1;
      acc_cnt_next    = acc_cnt_reg + cnt_t'(1);
    end

    case (state_reg)
      ACCUM: begin
        if (pipe_valid_reg) begin
          if (add_cnt_reg == LAST_CNT) begin
            // Final term: publish the sum and start the next one from zero.
            acc_out_next   = add_acc;
            overflow_next  = add_sticky;
            out_valid_next = 1'b1;
            acc_next       = '0;
            sticky_next    = 1'b0;
            acc_cnt_next   = '0;
            add_cnt_next   = '0;
            state_next     = HOLD;
          end else begin
            acc_next     = add_acc;
            sticky_next  = add_sticky;
            add_cnt_next = add_cnt_reg + cnt_t'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase

    // Flush drops the partial sum, any captured operand and a pending result.
    if (clear) begin
      pipe_valid_next = 1'b0;
      acc_next        = '0;
      sticky_next     = 1'b0;
      acc_cnt_next    = '0;
      add_cnt_next    = '0;
      out_valid_next  = 1'b0;
      acc_out_next    = '0;
      overflow_next   = 1'b0;
      state_next      = ACCUM;
    end

    // Registered ready looks at next-cycle state, so it never over-accepts.
    in_ready_next = (state_next == ACCUM) && (acc_cnt_next < N_CNT);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      pipe_valid_reg <= 1'b0;
      acc_reg        <= '0;
      sticky_reg     <= 1'b0;
      acc_cnt_reg    <= '0;
      add_cnt_reg    <= '0;
      out_valid_reg  <= 1'b0;
      acc_out_reg    <= '0;
      overflow_reg   <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      pipe_valid_reg <= pipe_valid_next;
      acc_reg        <= acc_next;
      sticky_reg     <= sticky_next;
      acc_cnt_reg    <= acc_cnt_next;
      add_cnt_reg    <= add_cnt_next;
      out_valid_reg  <= out_valid_next;
      acc_out_reg    <= acc_out_next;
      overflow_reg   <= overflow_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign acc_out   = acc_out_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mult_accum_4bit.sv
// Testbench for mult_accum_4bit: three instances (defaults, ACC_W=8,
// N_TERMS=1) driven by directed and randomized terms, checked against a
// sum-of-products reference model.
module tb_mult_accum_4bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_v     [3];
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic [3:0]  a_v         [3];
  logic [3:0]  b_v         [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic        overflow_v  [3];
  logic [11:0] acc_v       [3];
  logic [7:0]  acc8;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int sum_m    [3];
  int cnt_m    [3];
  int pend_acc [3];
  int pend_ovf [3];
  bit pend_has [3];
  int last_acc [3];
  int last_ovf [3];

  always #5 clk = ~clk;

  mult_accum_4bit dut0 (
    .clk(clk), .rst(rst), .clear(clear_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .acc_out(acc_v[0]), .overflow(overflow_v[0])
  );

  mult_accum_4bit #(.ACC_W(8)) dut_w8 (
    .clk(clk), .rst(rst), .clear(clear_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .acc_out(acc8), .overflow(overflow_v[1])
  );
  assign acc_v[1] = {4'b0000, acc8};

  mult_accum_4bit #(.N_TERMS(1)) dut_n1 (
    .clk(clk), .rst(rst), .clear(clear_v[2]),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .acc_out(acc_v[2]), .overflow(overflow_v[2])
  );

  function automatic int n_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int w_of(input int i);
    return (i == 1) ? 8 : 12;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  // Model: a completed group's result is the plain integer sum, wrapped or clamped.
  task automatic model_add(input int i, input int pa, input int pb);
    int maxv;
    sum_m[i] += pa * pb;
    cnt_m[i]++;
    if (cnt_m[i] == n_of(i)) begin
      maxv        = (1 << w_of(i)) - 1;
      pend_ovf[i] = (sum_m[i] > maxv) ? 1 : 0;
`ifdef MULT_ACCUM_SAT_EN
      pend_acc[i] = (sum_m[i] > maxv) ? maxv : sum_m[i];
`else
      pend_acc[i] = sum_m[i] % (maxv + 1);
`endif
      pend_has[i] = 1'b1;
      sum_m[i]    = 0;
      cnt_m[i]    = 0;
    end
  endtask

  task automatic model_reset(input int i);
    sum_m[i]    = 0;
    cnt_m[i]    = 0;
    pend_has[i] = 1'b0;
  endtask

  // Observe all result ports at the current falling edge, then advance one cycle.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      if (out_valid_v[i]) begin
        if (!pend_has[i]) begin
          check("spurious_valid", i, 32'(out_valid_v[i]), 32'd0);
        end else begin
          check("acc_out", i, 32'(acc_v[i]), 32'(pend_acc[i]));
          check("overflow", i, 32'(overflow_v[i]), 32'(pend_ovf[i]));
          if (out_ready_v[i]) begin
            last_acc[i] = int'(acc_v[i]);
            last_ovf[i] = int'(overflow_v[i]);
            pend_has[i] = 1'b0;
            $display("dut%0d result acc_out=%0d overflow=%0d expected %0d/%0d",
                     i, acc_v[i], overflow_v[i], pend_acc[i], pend_ovf[i]);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int i, input int pa, input int pb);
    int t = 0;
    in_valid_v[i] = 1'b1;
    a_v[i]        = 4'(pa);
    b_v[i]        = 4'(pb);
    while (!in_ready_v[i] && t < 20) begin
      step();
      t++;
    end
    check("accept_timeout", i, 32'(in_ready_v[i]), 32'd1);
    step();
    model_add(i, pa, pb);
    in_valid_v[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int t = 0;
    out_ready_v[i] = 1'b1;
    while (pend_has[i] && t < 30) begin
      step();
      t++;
    end
    check("drain_timeout", i, 32'(pend_has[i]), 32'd0);
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_v[i] = 1'b0; in_valid_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
      out_ready_v[i] = 1'b0; model_reset(i); last_acc[i] = -1; last_ovf[i] = -1;
    end
    repeat (3) @(negedge clk);
    // Reset state
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", i, 32'(in_ready_v[i]), 32'd0);
      check("rst_out_valid", i, 32'(out_valid_v[i]), 32'd0);
      check("rst_acc_out", i, 32'(acc_v[i]), 32'd0);
      check("rst_overflow", i, 32'(overflow_v[i]), 32'd0);
    end
    rst = 1'b0;
    step();

    // 1: four consecutive terms, latency of one edge after the last accept
    out_ready_v[0] = 1'b1;
    send(0, 13, 9); send(0, 10, 11); send(0, 8, 8); send(0, 15, 1);
    check("lat_before", 0, 32'(out_valid_v[0]), 32'd0);
    step();
    check("lat_valid", 0, 32'(out_valid_v[0]), 32'd1);
    drain(0);
    check("sum_306", 0, 32'(last_acc[0]), 32'd306);
    check("sum_306_ovf", 0, 32'(last_ovf[0]), 32'd0);

    // 2: ACC_W=8 overflow
    for (int k = 0; k < 4; k++) send(1, 15, 15);
    drain(1);
`ifdef MULT_ACCUM_SAT_EN
    check("ovf_acc", 1, 32'(last_acc[1]), 32'd255);
`else
    check("ovf_acc", 1, 32'(last_acc[1]), 32'd132);
`endif
    check("ovf_flag", 1, 32'(last_ovf[1]), 32'd1);

    // 3: backpressure holds the result and blocks input
    out_ready_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    for (int t = 0; t < 10 && !out_valid_v[0]; t++) step();
    a0 = int'(acc_v[0]);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_acc_stable", 0, 32'(acc_v[0]), 32'(a0));
      check("bp_valid", 0, 32'(out_valid_v[0]), 32'd1);
      check("bp_in_ready", 0, 32'(in_ready_v[0]), 32'd0);
    end
    out_ready_v[0] = 1'b1;
    step();
    check("bp_valid_drop", 0, 32'(out_valid_v[0]), 32'd0);
    check("bp_ready_rise", 0, 32'(in_ready_v[0]), 32'd1);

    // 4: gaps plus clear
    send(0, 7, 7); step(); send(0, 2, 2);
    clear_v[0] = 1'b1;
    step();
    clear_v[0] = 1'b0;
    model_reset(0);
    check("clear_valid", 0, 32'(out_valid_v[0]), 32'd0);
    send(0, 5, 4); step(); send(0, 1, 6); step(); step(); send(0, 0, 0); step(); send(0, 3, 3);
    drain(0);
    check("clear_sum", 0, 32'(last_acc[0]), 32'd35);

    // 5: reset mid-sum
    for (int k = 0; k < 3; k++) send(0, int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
    rst = 1'b1;
    step();
    check("midrst_valid", 0, 32'(out_valid_v[0]), 32'd0);
    check("midrst_acc", 0, 32'(acc_v[0]), 32'd0);
    check("midrst_ovf", 0, 32'(overflow_v[0]), 32'd0);
    check("midrst_ready", 0, 32'(in_ready_v[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    for (int k = 0; k < 4; k++) send(0, 1, 1);
    drain(0);
    check("rst_sum", 0, 32'(last_acc[0]), 32'd4);

    // 6: N_TERMS=1 stream
    out_ready_v[2] = 1'b1;
    send(2, 15, 15);
    check("n1_lat_before", 2, 32'(out_valid_v[2]), 32'd0);
    step();
    check("n1_lat_valid", 2, 32'(out_valid_v[2]), 32'd1);
    step();
    check("n1_first", 2, 32'(last_acc[2]), 32'd225);
    send(2, 1, 2);
    check("n1_lat2_before", 2, 32'(out_valid_v[2]), 32'd0);
    step();
    check("n1_lat2_valid", 2, 32'(out_valid_v[2]), 32'd1);
    step();
    check("n1_second", 2, 32'(last_acc[2]), 32'd2);

    // Randomized groups with gaps and result stalls on every instance
    for (int it = 0; it < 24; it++) begin
      int i;
      i = it % 3;
      out_ready_v[i] = 1'b0;
      for (int k = 0; k < n_of(i); k++) begin
        repeat ($urandom_range(0, 2)) step();
        send(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      repeat ($urandom_range(0, 3)) step();
      drain(i);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_accum_4bit.md
Name: mult_accum_4bit

Overview:
Downstream consumer of the 4-bit array multiplier (ArrMult_4bit), turning it into a small multiply-accumulate unit. It accepts operand pairs over a valid/ready handshake, registers them, and feeds them to ArrMult_4bit. Each 8-bit product is summed into an accumulator, and after N_TERMS products the sum is presented on a valid/ready output port. It sits between an operand source (test sequencer or datapath) and any result consumer.

Parameters:
N_TERMS, 4, products summed per result; legal range 1..255.
ACC_W, 12, accumulator/result width in bits; must be >= 8.

Ports:
clk  in  1  rising-edge clock, the only clock.
rst  in  1  synchronous, active-high reset.
clear  in  1  synchronous flush of the in-progress sum.
in_valid  in  1  operand pair present.
in_ready  out  1  block can accept an operand pair.
a  in  4  multiplicand, unsigned.
b  in  4  multiplier, unsigned.
out_valid  out  1  acc_out holds a completed sum.
out_ready  in  1  consumer takes the result.
acc_out  out  ACC_W  completed sum of N_TERMS products, unsigned.
overflow  out  1  the sum in acc_out exceeded 2^ACC_W-1; valid while out_valid=1.

Behaviour:
- Reset is synchronous: rst=1 at a rising edge overrides everything. All outputs and state then go to 0: in_ready, out_valid, acc_out, overflow, the operand register, pipe_valid, the accumulator, both counters, and the FSM (ACCUM).
- A transfer occurs at an edge where in_valid & in_ready = 1. At that edge, a/b are captured into the operand register and pipe_valid is set. Otherwise pipe_valid is cleared.
- The operand register drives ArrMult_4bit. At the next edge, when pipe_valid=1, the accumulator loads acc + zero-extended prod.
- Latency: if the last term is accepted at edge k, out_valid=1 after edge k+1.
- FSM states: ACCUM and HOLD.
- ACCUM:
  - in_ready = (acc_cnt < N_TERMS).
  - acc_cnt counts accepted pairs; add_cnt counts products added.
  - When a product is added and add_cnt == N_TERMS-1:
    - acc_out <= final sum and overflow <= final flag.
    - out_valid <= 1.
    - accumulator, sticky overflow flag and both counters are zeroed.
    - Go to HOLD.
- HOLD:
  - in_ready=0.
  - acc_out and overflow are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid <= 0 and go to ACCUM. in_ready rises the following cycle, so there is one bubble per result.
- in_valid gaps: tolerated. Terms may arrive on non-consecutive cycles, and the sum is order- and gap-independent.
- Arithmetic: unsigned, modulo 2^ACC_W (default build). An internal sticky flag is set whenever an addition carries out of ACC_W bits.
- clear=1 (and rst=0) at an edge:
  - pipe_valid, accumulator, sticky flag and counters are zeroed, and the FSM returns to ACCUM.
  - Any operand accepted in that same cycle is discarded.
  - out_valid, acc_out and overflow are zeroed as well (pending result dropped).
- N_TERMS=1: every accepted pair produces a result after 2 edges.
- a or b equal to 0: a valid term contributing 0; it still counts.

Optional Feature:
MULT_ACCUM_SAT_EN.
- Defined: an accumulation that would exceed 2^ACC_W-1 clamps the accumulator to all-ones and stays there for the rest of the sum. overflow is still set.
- Undefined: modulo wrap as described above, with overflow flagging the wrap.
- The handshake and latency are identical in both builds.

Decomposition:
- Package mult_accum_pkg holds:
  - OP_W=4 and PROD_W=8.
  - The FSM state typedef (ACCUM, HOLD).
  - A width-safe counter type sized for N_TERMS.
- ArrMult_4bit is instantiated unmodified as the single sub-module. No other sub-module is needed.

Test Plan:
1. Defaults; pairs (13,9), (10,11), (8,8), (15,1) on 4 consecutive cycles, out_ready=1 -> out_valid high 1 cycle after the last accept; acc_out=306 (0x132); overflow=0.
2. ACC_W=8; 4 × (15,15) -> acc_out=132 (0x84), overflow=1. With MULT_ACCUM_SAT_EN -> acc_out=255, overflow=1.
3. Backpressure: complete a sum with out_ready=0 for 3 cycles -> acc_out and out_valid stable, in_ready=0. Then out_ready=1 -> out_valid drops, and in_ready=1 on the next cycle.
4. Gaps plus clear: accept (7,7) and (2,2); pulse clear; then accept (5,4), (1,6), (0,0), (3,3), with in_valid low between pairs -> acc_out=35, with no contribution from before the clear.
5. Reset mid-sum: after 3 terms assert rst for 1 cycle -> all outputs 0. The next 4 terms (1,1) ×4 -> acc_out=4.
6. N_TERMS=1: a stream of (15,15), (1,2) with out_ready=1 -> results 225 then 2, each 2 edges after its accept.
